// File: rtl/barrett_3.sv
// Digit-serial MSD-first Barrett modular multiplier (radix 2^m) with a carry-save accumulator.
// Define BARRETT_QMU_DEBUG_EN to expose the per-cycle T*mu product on port q_mu.
module barrett_3 #(
  parameter int n = 24,
  parameter int m = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [n-1:0]      X,
  input  logic [m-1:0]      Y_i,
  input  logic [n-1:0]      M,
  input  logic [m+4:0]      mu,
  output logic [n+m+11:0]   ZS_reg,
  output logic [n+m+11:0]   ZC_reg
`ifdef BARRETT_QMU_DEBUG_EN
  ,
  output logic [2*m+8:0]    q_mu
`endif
);

  localparam int W  = n + m + 12;
  localparam int TW = m + 4;
  localparam int PW = 2 * m + 9;

  logic [W-1:0]  zs_q, zs_d;
  logic [W-1:0]  zc_q, zc_d;
  logic [TW-1:0] t_est;
  logic [PW-1:0] t_mu;
  logic [TW-1:0] q_est;

  logic [W-1:0]  acc_s, acc_c, pp;
  logic [W-1:0]  m_sh, x_sh;
  logic [TW-1:0] q_sh;
  logic [m-1:0]  y_sh;

  // 3:2 compressor; the carry vector comes back already weighted by 2
  function automatic logic [2*W-1:0] csa(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    return {a ^ b ^ c, ((a & b) | (a & c) | (b & c)) << 1};
  endfunction

  // Quotient estimate needs the exact top field, so the full carry chain is resolved here
  always_comb begin
    t_est = TW'((zs_q + zc_q) >> (n - 1));
    t_mu  = PW'(t_est) * PW'(mu);
    q_est = TW'(t_mu >> (m + 5));
  end

  // Fold 2^m*Z, -2^m*q*M and X*Y_i into a new carry-save pair.
  // Each q*M partial product enters inverted; the TW missing +1s are added as one constant.
  always_comb begin
    acc_s = zs_q << m;
    acc_c = zc_q << m;
    pp    = '0;
    m_sh  = W'(M) << m;
    q_sh  = q_est;
    for (int j = 0; j < TW; j++) begin
      pp = m_sh & {W{q_sh[0]}};
      {acc_s, acc_c} = csa(acc_s, acc_c, ~pp);
      m_sh = m_sh << 1;
      q_sh = q_sh >> 1;
    end
    x_sh = W'(X);
    y_sh = Y_i;
    for (int j = 0; j < m; j++) begin
      pp = x_sh & {W{y_sh[0]}};
      {acc_s, acc_c} = csa(acc_s, acc_c, pp);
      x_sh = x_sh << 1;
      y_sh = y_sh >> 1;
    end
    {acc_s, acc_c} = csa(acc_s, acc_c, W'(TW));
    zs_d = acc_s;
    zc_d = acc_c;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      zs_q <= '0;
      zc_q <= '0;
    end else begin
      zs_q <= zs_d;
      zc_q <= zc_d;
    end
  end

  assign ZS_reg = zs_q;
  assign ZC_reg = zc_q;

`ifdef BARRETT_QMU_DEBUG_EN
  assign q_mu = t_mu;
`endif

endmodule

// File: tb/tb_barrett_3.sv
// Self-checking bench for barrett_3: directed vector table, mid-operation reset, random regression.
module tb_barrett_3;

  localparam int N = 24;
  localparam int MW = 4;
  localparam int K = N / MW;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [23:0] X = '0;
  logic [23:0] M = 24'd16777215;
  logic [3:0]  Y_i = '0;
  logic [8:0]  mu = 9'd256;
  logic [39:0] ZS_reg, ZC_reg;
`ifdef BARRETT_QMU_DEBUG_EN
  logic [16:0] q_mu;
`endif

  int total = 0;
  int bad = 0;
  longint unsigned z_model;

  barrett_3 #(.n(N), .m(MW)) dut (
    .CLK(CLK),
    .RST(RST),
    .X(X),
    .Y_i(Y_i),
    .M(M),
    .mu(mu),
    .ZS_reg(ZS_reg),
`ifdef BARRETT_QMU_DEBUG_EN
    .q_mu(q_mu),
`endif
    .ZC_reg(ZC_reg)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    longint unsigned x;
    longint unsigned y;
    longint unsigned md;
    bit              z_known;
    longint unsigned z_exp;
    longint unsigned r_exp;
  } vec_t;

  function automatic longint unsigned dut_z();
    logic [39:0] s;
    s = ZS_reg + ZC_reg;
    return 64'(s);
  endfunction

  function automatic longint unsigned model_step(longint unsigned z, longint unsigned x,
                                                 longint unsigned y, longint unsigned md,
                                                 longint unsigned muv);
    longint unsigned t, q;
    t = (z >> 23) & 64'd255;
    q = (t * muv) >> 9;
    return (((z - q * md) << 4) + x * y) & 64'hFF_FFFF_FFFF;
  endfunction

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    RST = 1'b0;
    Y_i = '0;
    @(negedge CLK);
    RST = 1'b1;
    z_model = 0;
  endtask

  // One full operation: reset, k digits MSD first, one zero digit; Z compared every cycle
  task automatic applyStimulus(input longint unsigned x, input longint unsigned y,
                               input longint unsigned md, output longint unsigned z_out);
    longint unsigned muv;
    muv = (64'd1 << 32) / md;
    X  = 24'(x);
    M  = 24'(md);
    mu = 9'(muv);
    reset_pulse();
    for (int c = 0; c <= K; c++) begin
      Y_i = (c < K) ? 4'((y >> (4 * (K - 1 - c))) & 64'hF) : 4'd0;
      @(posedge CLK);
      #1;
      z_model = model_step(z_model, x, 64'(Y_i), md, muv);
      checkOutput("z_cycle", dut_z(), z_model);
      @(negedge CLK);
    end
    z_out = dut_z();
  endtask

  task automatic check_result(input longint unsigned z, input longint unsigned md,
                              input longint unsigned r_exp);
    longint unsigned r;
    checkOutput("z_low_zero", z & 64'hF, 0);
    checkOutput("z_below_2p31", 64'(z < (64'd1 << 31)), 1);
    r = z >> 4;
    checkOutput("r_below_4m", 64'(r < 4 * md), 1);
    for (int i = 0; i < 3; i++) if (r >= md) r = r - md;
    checkOutput("r_reduced", r, r_exp);
  endtask

  vec_t vecs[6];
  longint unsigned z_res, rx, ry, rm;

  initial begin
    vecs[0] = '{x: 0,        y: 0,        md: 16777215, z_known: 1, z_exp: 0,   r_exp: 0};
    vecs[1] = '{x: 1,        y: 1,        md: 16777215, z_known: 1, z_exp: 16,  r_exp: 1};
    vecs[2] = '{x: 16777214, y: 16777214, md: 16777215, z_known: 0, z_exp: 0,   r_exp: 1};
    vecs[3] = '{x: 8388608,  y: 2,        md: 8388609,  z_known: 0, z_exp: 0,   r_exp: 8388607};
    vecs[4] = '{x: 3,        y: 5,        md: 16777215, z_known: 1, z_exp: 240, r_exp: 15};
    vecs[5] = '{x: 16777215, y: 12345,    md: 16777215, z_known: 0, z_exp: 0,   r_exp: 0};

    #2;
    checkOutput("reset_zs", 64'(ZS_reg), 0);
    checkOutput("reset_zc", 64'(ZC_reg), 0);
    RST = 1'b1;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].x, vecs[v].y, vecs[v].md, z_res);
      if (vecs[v].z_known) checkOutput("z_final", z_res, vecs[v].z_exp);
      check_result(z_res, vecs[v].md, vecs[v].r_exp);
    end

    // Abort mid-operation: reset clears both registers without a clock edge and holds them
    X  = 24'd16777214;
    M  = 24'd16777215;
    mu = 9'd256;
    reset_pulse();
    for (int c = 0; c < 3; c++) begin
      Y_i = 4'hF;
      @(posedge CLK);
      #1;
      z_model = model_step(z_model, 64'd16777214, 64'd15, 64'd16777215, 64'd256);
      checkOutput("abort_pre_z", dut_z(), z_model);
      @(negedge CLK);
    end
    checkOutput("abort_pre_nonzero", 64'(dut_z() != 0), 1);
    RST = 1'b0;
    #1;
    checkOutput("abort_zs", 64'(ZS_reg), 0);
    checkOutput("abort_zc", 64'(ZC_reg), 0);
    @(posedge CLK);
    #1;
    checkOutput("abort_hold_zs", 64'(ZS_reg), 0);
    checkOutput("abort_hold_zc", 64'(ZC_reg), 0);

    applyStimulus(64'd16777214, 64'd16777214, 64'd16777215, z_res);
    check_result(z_res, 64'd16777215, 64'd1);

    for (int i = 0; i < 1000; i++) begin
      rm = 64'd8388609 + 64'($urandom_range(0, 32'd8388605));
      rx = 64'($urandom_range(0, 32'd16777215));
      ry = 64'($urandom_range(0, 32'd16777215));
      applyStimulus(rx, ry, rm, z_res);
      check_result(z_res, rm, (rx * ry) % rm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
